// File: rtl/video_timing_gen.sv
// Raster timing generator and RGB565->RGB888 pixel formatter with window borders.
// Optional colour-bar test pattern is built only when VIDEO_TEST_PATTERN_EN is defined.
module video_timing_gen #(
    parameter int          H_SYNC     = 96,
    parameter int          H_BACK     = 48,
    parameter int          H_DISP     = 640,
    parameter int          H_FRONT    = 16,
    parameter int          V_SYNC     = 2,
    parameter int          V_BACK     = 33,
    parameter int          V_DISP     = 480,
    parameter int          V_FRONT    = 10,
    parameter int          HS_POL     = 0,
    parameter int          VS_POL     = 0,
    parameter int          DATA_LAT   = 1,
    parameter int          COORD_W    = 12,
    parameter logic [23:0] BORDER_RGB = 24'ha0a000
) (
    input  logic               pixel_clk,
    input  logic               sys_rst_n,
    input  logic               timing_en,
    input  logic [COORD_W-1:0] win_x0,
    input  logic [COORD_W-1:0] win_x1,
    input  logic [COORD_W-1:0] win_y0,
    input  logic [COORD_W-1:0] win_y1,
    input  logic               test_mode,
    output logic               pixel_req,
    output logic [COORD_W-1:0] pixel_xpos,
    output logic [COORD_W-1:0] pixel_ypos,
    input  logic [15:0]        video_rgb_565,
    output logic               video_hs,
    output logic               video_vs,
    output logic               video_de,
    output logic [23:0]        video_rgb,
    output logic               frame_start,
    output logic               line_start,
    output logic [15:0]        frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] HA_C   = COORD_W'(HA);
    localparam logic [COORD_W-1:0] VA_C   = COORD_W'(VA);
    localparam logic [COORD_W-1:0] H_END  = COORD_W'(HA + H_DISP);
    localparam logic [COORD_W-1:0] V_END  = COORD_W'(VA + V_DISP);
    localparam logic [COORD_W-1:0] REQ_H0 = COORD_W'(HA - DATA_LAT);
    localparam logic [COORD_W-1:0] REQ_H1 = COORD_W'(HA + H_DISP - DATA_LAT);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);
    localparam logic               HS_ACT = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic               VS_ACT = (VS_POL != 0) ? 1'b1 : 1'b0;

    logic [COORD_W-1:0] cnt_h_r;
    logic [COORD_W-1:0] cnt_v_r;
    logic [COORD_W-1:0] win_x0_r;
    logic [COORD_W-1:0] win_x1_r;
    logic [COORD_W-1:0] win_y0_r;
    logic [COORD_W-1:0] win_y1_r;
    logic [COORD_W-1:0] disp_x_s;
    logic [COORD_W-1:0] disp_y_s;
    logic               h_act_s;
    logic               v_act_s;
    logic               act_s;
    logic               req_s;
    logic               in_win_s;
    logic [23:0]        pix_s;

    // Bit replication-free expansion: low bits of each channel are zero-filled.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
    endfunction

    // Horizontal/vertical raster counters; disable parks them at the origin.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_r <= '0;
            cnt_v_r <= '0;
        end else if (!timing_en) begin
            cnt_h_r <= '0;
            cnt_v_r <= '0;
        end else if (cnt_h_r == H_LAST) begin
            cnt_h_r <= '0;
            cnt_v_r <= (cnt_v_r == V_LAST) ? '0 : cnt_v_r + ONE_C;
        end else begin
            cnt_h_r <= cnt_h_r + ONE_C;
        end
    end

    // Completed-frame counter, held while the raster is disabled.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt <= 16'd0;
        end else if (timing_en && (cnt_h_r == H_LAST) && (cnt_v_r == V_LAST)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Window shadows only change at the raster origin so a frame never tears.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win_x0_r <= '0;
            win_x1_r <= '0;
            win_y0_r <= '0;
            win_y1_r <= '0;
        end else if ((cnt_h_r == '0) && (cnt_v_r == '0)) begin
            win_x0_r <= win_x0;
            win_x1_r <= win_x1;
            win_y0_r <= win_y0;
            win_y1_r <= win_y1;
        end
    end

    assign h_act_s  = (cnt_h_r >= HA_C) && (cnt_h_r < H_END);
    assign v_act_s  = (cnt_v_r >= VA_C) && (cnt_v_r < V_END);
    assign act_s    = h_act_s && v_act_s;
    assign req_s    = v_act_s && (cnt_h_r >= REQ_H0) && (cnt_h_r < REQ_H1);
    assign disp_x_s = cnt_h_r - HA_C;
    assign disp_y_s = cnt_v_r - VA_C;
    // An inverted or zero-size window matches no pixel, giving an all-border frame.
    assign in_win_s = (disp_x_s >= win_x0_r) && (disp_x_s < win_x1_r) &&
                      (disp_y_s >= win_y0_r) && (disp_y_s < win_y1_r);

    // Pixel request runs DATA_LAT clocks ahead of the active column.
    always_comb begin
        pixel_req  = 1'b0;
        pixel_xpos = '0;
        pixel_ypos = '0;
        if (req_s) begin
            pixel_req  = 1'b1;
            pixel_xpos = cnt_h_r - REQ_H0;
            pixel_ypos = disp_y_s;
        end else begin
            pixel_req  = 1'b0;
            pixel_xpos = '0;
            pixel_ypos = '0;
        end
    end

`ifdef VIDEO_TEST_PATTERN_EN
    localparam logic [COORD_W-1:0] BAR_W = COORD_W'(H_DISP / 8);

    logic [COORD_W-1:0] bar_q_s;
    logic [2:0]         bar_idx_s;
    logic [23:0]        bar_rgb_s;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hffffff;
            3'd1:    return 24'hffff00;
            3'd2:    return 24'h00ffff;
            3'd3:    return 24'h00ff00;
            3'd4:    return 24'hff00ff;
            3'd5:    return 24'hff0000;
            3'd6:    return 24'h0000ff;
            default: return 24'h000000;
        endcase
    endfunction

    assign bar_q_s   = disp_x_s / BAR_W;
    assign bar_idx_s = (bar_q_s > COORD_W'(7)) ? 3'd7 : bar_q_s[2:0];
    assign bar_rgb_s = bar_colour(bar_idx_s);

    // Active-area colour: bars override window and source data.
    always_comb begin
        pix_s = 24'h000000;
        if (!act_s) begin
            pix_s = 24'h000000;
        end else if (test_mode) begin
            pix_s = bar_rgb_s;
        end else if (in_win_s) begin
            pix_s = rgb565_to_888(video_rgb_565);
        end else begin
            pix_s = BORDER_RGB;
        end
    end
`else
    logic unused_test_mode_s;
    assign unused_test_mode_s = test_mode;

    // Active-area colour: source pixel inside the window, border outside.
    always_comb begin
        pix_s = 24'h000000;
        if (!act_s) begin
            pix_s = 24'h000000;
        end else if (in_win_s) begin
            pix_s = rgb565_to_888(video_rgb_565);
        end else begin
            pix_s = BORDER_RGB;
        end
    end
`endif

    // Registered video outputs and strobes, one clock behind the counters.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            video_hs    <= ~HS_ACT;
            video_vs    <= ~VS_ACT;
            video_de    <= 1'b0;
            video_rgb   <= 24'h000000;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!timing_en) begin
            video_hs    <= ~HS_ACT;
            video_vs    <= ~VS_ACT;
            video_de    <= 1'b0;
            video_rgb   <= 24'h000000;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_hs    <= (cnt_h_r < HS_END) ? HS_ACT : ~HS_ACT;
            video_vs    <= (cnt_v_r < VS_END) ? VS_ACT : ~VS_ACT;
            video_de    <= act_s;
            video_rgb   <= pix_s;
            line_start  <= v_act_s && (cnt_h_r == HA_C);
            frame_start <= v_act_s && (cnt_h_r == HA_C) && (cnt_v_r == VA_C);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced 28x12 raster with DATA_LAT=3.
module tb_video_timing_gen;

    localparam int HS = 4, HB = 4, HD = 16, HF = 4;
    localparam int VS = 2, VB = 2, VD = 6, VF = 2;
    localparam int LAT = 3;
    localparam int HT = HS + HB + HD + HF;   // 28
    localparam int VT = VS + VB + VD + VF;   // 12
    localparam int HA = HS + HB;             // 8
    localparam int VA = VS + VB;             // 4

    logic        pixel_clk = 1'b0;
    logic        sys_rst_n;
    logic        timing_en;
    logic [11:0] win_x0, win_x1, win_y0, win_y1;
    logic        test_mode;
    logic        pixel_req;
    logic [11:0] pixel_xpos, pixel_ypos;
    logic [15:0] video_rgb_565;
    logic        video_hs, video_vs, video_de;
    logic [23:0] video_rgb;
    logic        frame_start, line_start;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int src_mode = 0;
    int de_total = 0, hs_low = 0, vs_low = 0;

    logic [23:0] exp_q[$];
    logic [15:0] hist[0:8];

    video_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .HS_POL(0), .VS_POL(0), .DATA_LAT(LAT), .COORD_W(12),
        .BORDER_RGB(24'ha0a000)
    ) dut (
        .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .timing_en(timing_en),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .test_mode(test_mode), .pixel_req(pixel_req), .pixel_xpos(pixel_xpos),
        .pixel_ypos(pixel_ypos), .video_rgb_565(video_rgb_565),
        .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
        .video_rgb(video_rgb), .frame_start(frame_start), .line_start(line_start),
        .frame_cnt(frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic note_fail(input string nm, input logic [31:0] act, input logic [31:0] exp);
        errors++;
        $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
        if (errors >= 40) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) note_fail(nm, act, exp);
    endtask

    function automatic logic [15:0] src_pix(input int x, input int y, input int mode);
        logic [11:0] xl, yl;
        xl = x[11:0];
        yl = y[11:0];
        return (mode != 0) ? 16'hFFFF : {xl[4:0], yl[5:0], 5'd0};
    endfunction

`ifdef VIDEO_TEST_PATTERN_EN
    logic [23:0] bars [0:7] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};
`endif

    // Reference raster, pixel source and scoreboard, all evaluated mid-cycle.
    initial begin
        int rh, rv, rframe, x, y, sx0, sx1, sy0, sy1;
        logic e_hs, e_vs, e_de, e_ls, e_fs, m_req, inw;
        logic [11:0] xl, yl;
        logic [23:0] e_rgb;
        video_rgb_565 = 16'hDEAD;
        rh = 0; rv = 0; rframe = 0; sx0 = 0; sx1 = 0; sy0 = 0; sy1 = 0;
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
        for (int i = 0; i < 9; i++) hist[i] = 16'hDEAD;
        forever begin
            @(negedge pixel_clk);
            if (!sys_rst_n) begin
                chk("rst_hs", 32'(video_hs), 32'd1);
                chk("rst_vs", 32'(video_vs), 32'd1);
                chk("rst_de", 32'(video_de), 32'd0);
                chk("rst_rgb", 32'(video_rgb), 32'd0);
                chk("rst_ls", 32'(line_start), 32'd0);
                chk("rst_fs", 32'(frame_start), 32'd0);
                chk("rst_fcnt", 32'(frame_cnt), 32'd0);
                chk("rst_req", 32'(pixel_req), 32'd0);
                rh = 0; rv = 0; rframe = 0; sx0 = 0; sx1 = 0; sy0 = 0; sy1 = 0;
                e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
                exp_q.delete();
                for (int i = 0; i < 9; i++) hist[i] = 16'hDEAD;
                video_rgb_565 = 16'hDEAD;
            end else begin
                chk("hs", 32'(video_hs), 32'(e_hs));
                chk("vs", 32'(video_vs), 32'(e_vs));
                chk("de", 32'(video_de), 32'(e_de));
                chk("line_start", 32'(line_start), 32'(e_ls));
                chk("frame_start", 32'(frame_start), 32'(e_fs));
                chk("frame_cnt", 32'(frame_cnt), 32'(rframe));
                if (video_de) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        note_fail("rgb_unexpected", 32'(video_rgb), 32'd0);
                    end else begin
                        e_rgb = exp_q.pop_front();
                        chk("rgb", 32'(video_rgb), 32'(e_rgb));
                    end
                end else begin
                    chk("rgb_blank", 32'(video_rgb), 32'd0);
                end
                if (video_de) de_total++;
                if (!video_hs) hs_low++;
                if (!video_vs) vs_low++;

                m_req = (rv >= VA) && (rv < VA + VD) && (rh >= HA - LAT) && (rh < HA + HD - LAT);
                x = m_req ? rh - (HA - LAT) : 0;
                y = m_req ? rv - VA : 0;
                chk("pixel_req", 32'(pixel_req), 32'(m_req));
                chk("pixel_xpos", 32'(pixel_xpos), 32'(x));
                chk("pixel_ypos", 32'(pixel_ypos), 32'(y));

                for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = pixel_req ? src_pix(int'(pixel_xpos), int'(pixel_ypos), src_mode) : 16'hDEAD;
                video_rgb_565 = hist[LAT];

                if (m_req) begin
                    inw = (x >= sx0) && (x < sx1) && (y >= sy0) && (y < sy1);
                    xl = x[11:0];
                    yl = y[11:0];
                    if (!inw) e_rgb = 24'ha0a000;
                    else if (src_mode != 0) e_rgb = 24'hf8fcf8;
                    else e_rgb = {xl[4:0], 3'b000, yl[5:0], 2'b00, 8'h00};
`ifdef VIDEO_TEST_PATTERN_EN
                    if (test_mode) e_rgb = bars[x / (HD / 8)];
`endif
                    exp_q.push_back(e_rgb);
                end

                if (timing_en) begin
                    e_hs = (rh < HS) ? 1'b0 : 1'b1;
                    e_vs = (rv < VS) ? 1'b0 : 1'b1;
                    e_de = (rh >= HA) && (rh < HA + HD) && (rv >= VA) && (rv < VA + VD);
                    e_ls = (rh == HA) && (rv >= VA) && (rv < VA + VD);
                    e_fs = (rh == HA) && (rv == VA);
                end else begin
                    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0;
                    exp_q.delete();
                end

                if ((rh == 0) && (rv == 0)) begin
                    sx0 = int'(win_x0); sx1 = int'(win_x1);
                    sy0 = int'(win_y0); sy1 = int'(win_y1);
                end

                if (!timing_en) begin
                    rh = 0; rv = 0;
                end else if (rh == HT - 1) begin
                    rh = 0;
                    if (rv == VT - 1) begin
                        rv = 0;
                        rframe = (rframe + 1) & 16'hFFFF;
                    end else begin
                        rv = rv + 1;
                    end
                end else begin
                    rh = rh + 1;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    task automatic set_win(input int x0, input int y0, input int x1, input int y1);
        win_x0 = 12'(x0); win_y0 = 12'(y0); win_x1 = 12'(x1); win_y1 = 12'(y1);
    endtask

    // Directed stimulus sequence.
    initial begin
        int d0, h0, v0, n;
        bit seen;
        sys_rst_n = 1'b0;
        timing_en = 1'b0;
        test_mode = 1'b0;
        set_win(0, 0, HD, VD);
        cyc(3);
        sys_rst_n = 1'b1;
        timing_en = 1'b1;

        // One full frame: 96 DE cycles, 48 HS-low, 56 VS-low out of 336.
        cyc(10);
        d0 = de_total; h0 = hs_low; v0 = vs_low;
        cyc(HT * VT);
        chk("de_per_frame", 32'(de_total - d0), 32'd96);
        chk("hs_low_per_frame", 32'(hs_low - h0), 32'd48);
        chk("vs_low_per_frame", 32'(vs_low - v0), 32'd56);
        cyc(360);

        src_mode = 1;
        set_win(3, 1, 10, 4);
        cyc(700);
        set_win(0, 2, 8, 6);
        cyc(700);
        set_win(5, 0, 5, 6);
        cyc(400);
        set_win(0, 4, 16, 2);
        cyc(400);

        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cyc(1);
            if (pixel_req && (pixel_xpos == 12'd5)) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            note_fail("drop_sync_timeout", 32'd0, 32'd1);
        end
        timing_en = 1'b0;
        cyc(20);
        test_mode = 1'b1;
        src_mode = 0;
        set_win(0, 0, HD, VD);
        timing_en = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 600 && !seen) begin
            cyc(1);
            n++;
            if (frame_start) seen = 1'b1;
        end
        chk("restart_latency", 32'(n), 32'(VA * HT + HA + 1));
        cyc(400);

        sys_rst_n = 1'b0;
        cyc(2);
        sys_rst_n = 1'b1;
        cyc(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
